// File: rtl/dom_shared_inv_out_gf4_pkg.sv
// Shared types and GF(2^2) normal-basis helpers for the masked GF(2^4) inversion output stage.
package dom_shared_inv_out_gf4_pkg;

  localparam int GF2_W  = 2;
  localparam int GF4_W  = 4;
  localparam int XH_LSB = 2;
  localparam int XL_LSB = 0;

  // One GF(2^4) share split into its GF(2^2) halves.
  typedef struct packed {
    logic [GF2_W-1:0] xh;
    logic [GF2_W-1:0] xl;
  } gf4_split_t;

  // GF(2^2) multiply in normal basis; the multiplicative identity is 2'b11.
  function automatic logic [GF2_W-1:0] gf4_nb_mul(input logic [GF2_W-1:0] a,
                                                  input logic [GF2_W-1:0] b);
    logic e;
    e = (a[1] ^ a[0]) & (b[1] ^ b[0]);
    return {(a[1] & b[1]) ^ e, (a[0] & b[0]) ^ e};
  endfunction

  function automatic int n_rnd_pairs(input int shares);
    return shares * (shares - 1) / 2;
  endfunction

  // Row-major upper-triangle index of the share pair {i, j}; symmetric in i and j.
  function automatic int pair_idx(input int i, input int j, input int shares);
    int lo;
    int hi;
    lo = (i < j) ? i : j;
    hi = (i < j) ? j : i;
    return lo * shares - (lo * (lo + 1)) / 2 + (hi - lo - 1);
  endfunction

endpackage

// File: rtl/dom_indep_mul_gf2.sv
// DOM-indep shared GF(2^2) multiplier: every partial product is registered before shares mix.
module dom_indep_mul_gf2
  import dom_shared_inv_out_gf4_pkg::*;
#(
  parameter int SHARES = 2
) (
  input  logic                                ClkxCI,
  input  logic                                RstxRI,
  input  logic                                EnxSI,
  input  logic [GF2_W*SHARES-1:0]             _AxDI,
  input  logic [GF2_W*SHARES-1:0]             _BxDI,
  input  logic [GF2_W*n_rnd_pairs(SHARES)-1:0] _ZxDI,
  output logic [GF2_W*SHARES-1:0]             _QxDO
);

  localparam int NT = SHARES * SHARES;

  logic [GF2_W*NT-1:0] term;
  logic [GF2_W*NT-1:0] r;

  for (genvar i = 0; i < SHARES; i++) begin : g_row
    for (genvar j = 0; j < SHARES; j++) begin : g_col
      localparam int T = i * SHARES + j;
      logic [GF2_W-1:0] prod;

      gf2_mul #(.N(2)) u_pp (
        .a (_AxDI[GF2_W*i +: GF2_W]),
        .b (_BxDI[GF2_W*j +: GF2_W]),
        .q (prod)
      );

      if (i == j) begin : g_inner
        assign term[GF2_W*T +: GF2_W] = prod;
      end else begin : g_cross
        // The same Z word blinds both R[i][j] and R[j][i], so it cancels in the share sum.
        assign term[GF2_W*T +: GF2_W] = prod ^ _ZxDI[GF2_W*pair_idx(i, j, SHARES) +: GF2_W];
      end
    end
  end

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  // NOTE: the R array is small and security relevant, so it is reset like any other flop.
  always_ff @(posedge ClkxCI or posedge RstxRI) begin
    if (RstxRI) begin
      r <= '0;
    end else if (EnxSI) begin
      r <= term;
    end
  end

  // NOTE: always_comb outputs get a default first so no path can infer a latch.
  always_comb begin
    _QxDO = '0;
    for (int i = 0; i < SHARES; i++) begin
      for (int j = 0; j < SHARES; j++) begin
        _QxDO[GF2_W*i +: GF2_W] = _QxDO[GF2_W*i +: GF2_W] ^ r[GF2_W*(i*SHARES + j) +: GF2_W];
      end
    end
  end

endmodule

// File: rtl/gf2_mul.sv
// Combinational GF(2^2) normal-basis partial-product multiplier.
module gf2_mul
  import dom_shared_inv_out_gf4_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] q
);

  assign q = gf4_nb_mul(a, b);

endmodule

// File: rtl/dom_shared_inv_out_gf4.sv
// Masked GF(2^4) inversion output stage: aligns X with the upstream theta and forms {theta*Xl, theta*Xh}.
module dom_shared_inv_out_gf4
  import dom_shared_inv_out_gf4_pkg::*;
#(
  parameter int SHARES           = 2,
  parameter int UPSTREAM_LATENCY = 1
) (
  input  logic                            ClkxCI,
  input  logic                            RstxRI,
  input  logic                            ValidxSI,
  input  logic [GF4_W*SHARES-1:0]         _XxDI,
  input  logic [GF2_W*SHARES-1:0]         _InvxDI,
  input  logic [SHARES*(SHARES-1)*2-1:0]  _ZxDI,
  output logic [GF4_W*SHARES-1:0]         _QxDO,
  output logic                            ValidxSO
);

  localparam int L  = UPSTREAM_LATENCY;
  localparam int XW = GF4_W * SHARES;
  localparam int ZW = GF2_W * n_rnd_pairs(SHARES);

  logic [L-1:0]        align_v;
  logic [XW*L-1:0]     align_x;
  logic [L:0]          v_ext;
  logic [XW*(L+1)-1:0] x_ext;
  logic                v_d;
  logic [XW-1:0]       x_d;

  // Stage k reads slot k of the extended chain; slot 0 is the block input.
  assign v_ext = {align_v, ValidxSI};
  assign x_ext = {align_x, _XxDI};
  assign v_d   = v_ext[L];
  assign x_d   = x_ext[XW*L +: XW];

  always_ff @(posedge ClkxCI or posedge RstxRI) begin
    if (RstxRI) begin
      align_v <= '0;
      align_x <= '0;
    end else begin
      align_v <= v_ext[L-1:0];
      for (int k = 0; k < L; k++) begin
        if (v_ext[k]) begin
          align_x[XW*k +: XW] <= x_ext[XW*k +: XW];
        end
      end
    end
  end

  logic [GF2_W*SHARES-1:0] xh_sh;
  logic [GF2_W*SHARES-1:0] xl_sh;

  always_comb begin
    gf4_split_t s;
    xh_sh = '0;
    xl_sh = '0;
    for (int i = 0; i < SHARES; i++) begin
      s = x_d[GF4_W*i +: GF4_W];
      xh_sh[GF2_W*i +: GF2_W] = s.xh;
      xl_sh[GF2_W*i +: GF2_W] = s.xl;
    end
  end

  logic [GF2_W*SHARES-1:0] q_hi;
  logic [GF2_W*SHARES-1:0] q_lo;

  dom_indep_mul_gf2 #(.SHARES(SHARES)) u_mul_hi (
    .ClkxCI (ClkxCI),
    .RstxRI (RstxRI),
    .EnxSI  (v_d),
    ._AxDI  (_InvxDI),
    ._BxDI  (xl_sh),
    ._ZxDI  (_ZxDI[ZW-1:0]),
    ._QxDO  (q_hi)
  );

  dom_indep_mul_gf2 #(.SHARES(SHARES)) u_mul_lo (
    .ClkxCI (ClkxCI),
    .RstxRI (RstxRI),
    .EnxSI  (v_d),
    ._AxDI  (_InvxDI),
    ._BxDI  (xh_sh),
    ._ZxDI  (_ZxDI[2*ZW-1:ZW]),
    ._QxDO  (q_lo)
  );

  always_ff @(posedge ClkxCI or posedge RstxRI) begin
    if (RstxRI) begin
      ValidxSO <= 1'b0;
    end else begin
      ValidxSO <= v_d;
    end
  end

  always_comb begin
    _QxDO = '0;
    for (int i = 0; i < SHARES; i++) begin
      _QxDO[GF4_W*i + XH_LSB +: GF2_W] = q_hi[GF2_W*i +: GF2_W];
      _QxDO[GF4_W*i + XL_LSB +: GF2_W] = q_lo[GF2_W*i +: GF2_W];
    end
  end

endmodule

// File: tb/tb_dom_shared_inv_out_gf4.sv
// Self-checking bench: drives a 2-share/latency-1 and a 3-share/latency-2 instance against a GF(4) log-table model.
module tb_dom_shared_inv_out_gf4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        v2 = 0, vo2;
  logic [7:0]  x2 = '0, q2;
  logic [3:0]  inv2 = '0, z2 = '0;
  logic        v3 = 0, vo3;
  logic [11:0] x3 = '0, q3, z3 = '0;
  logic [5:0]  inv3 = '0;

  dom_shared_inv_out_gf4 #(.SHARES(2), .UPSTREAM_LATENCY(1)) dut2 (
    .ClkxCI(clk), .RstxRI(rst), .ValidxSI(v2), ._XxDI(x2), ._InvxDI(inv2),
    ._ZxDI(z2), ._QxDO(q2), .ValidxSO(vo2)
  );

  dom_shared_inv_out_gf4 #(.SHARES(3), .UPSTREAM_LATENCY(2)) dut3 (
    .ClkxCI(clk), .RstxRI(rst), .ValidxSI(v3), ._XxDI(x3), ._InvxDI(inv3),
    ._ZxDI(z3), ._QxDO(q3), .ValidxSO(vo3)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    int         due;
    logic [3:0] x;
  } beat_t;

  beat_t      pend2[$];
  beat_t      pend3[$];
  logic [3:0] exp_q2 = '0, exp_q3 = '0;
  bit         exp_v2 = 0, exp_v3 = 0;

  typedef struct {
    logic [3:0] x;
    logic [1:0] th;
    logic [3:0] q;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // GF(4) arithmetic through discrete logs: 11 = 1, 10 = g, 01 = g^2.
  function automatic int gf_log(input logic [1:0] a);
    case (a)
      2'b11:   return 0;
      2'b10:   return 1;
      default: return 2;
    endcase
  endfunction

  function automatic logic [1:0] gmul(input logic [1:0] a, input logic [1:0] b);
    int s;
    if (a == 2'b00 || b == 2'b00) return 2'b00;
    s = (gf_log(a) + gf_log(b)) % 3;
    case (s)
      0:       return 2'b11;
      1:       return 2'b10;
      default: return 2'b01;
    endcase
  endfunction

  function automatic logic [3:0] ref_out(input logic [1:0] th, input logic [3:0] x);
    return {gmul(th, x[1:0]), gmul(th, x[3:2])};
  endfunction

  function automatic logic [3:0] fold2(input logic [7:0] q);
    return q[3:0] ^ q[7:4];
  endfunction

  function automatic logic [3:0] fold3(input logic [11:0] q);
    return q[3:0] ^ q[7:4] ^ q[11:8];
  endfunction

  // One cycle: compare current outputs, drive new inputs, advance the model.
  // mode 0 = unmasked (upper shares and Z zero), 1 = fresh shares and Z, 2 = fixed shares, fresh Z.
  task automatic step(input bit do_rst, input bit v, input logic [3:0] x,
                      input logic [1:0] th, input int mode);
    logic [3:0] ra, rb;
    logic [1:0] ta, tb;
    beat_t      b;
    check("valid_s2", vo2, exp_v2);
    check("q_s2", fold2(q2), exp_q2);
    check("valid_s3", vo3, exp_v3);
    check("q_s3", fold3(q3), exp_q3);

    case (mode)
      0:       begin ra = 4'h0; rb = 4'h0; ta = 2'b00; tb = 2'b00; end
      1:       begin ra = 4'($urandom); rb = 4'($urandom); ta = 2'($urandom); tb = 2'($urandom); end
      default: begin ra = 4'h5; rb = 4'hA; ta = 2'b01; tb = 2'b10; end
    endcase
    rst  = do_rst;
    v2   = v;
    v3   = v;
    x2   = {ra, x ^ ra};
    x3   = {rb, ra, x ^ ra ^ rb};
    inv2 = {ta, th ^ ta};
    inv3 = {tb, ta, th ^ ta ^ tb};
    z2   = (mode == 0) ? 4'h0 : 4'($urandom);
    z3   = (mode == 0) ? 12'h0 : 12'($urandom);

    if (do_rst) begin
      #1;
      check("rst_q_s2", q2, 0);
      check("rst_valid_s2", vo2, 0);
      check("rst_q_s3", q3, 0);
      check("rst_valid_s3", vo3, 0);
      pend2.delete();
      pend3.delete();
      exp_q2 = '0; exp_v2 = 0;
      exp_q3 = '0; exp_v3 = 0;
    end else begin
      exp_v2 = 0;
      if (pend2.size() > 0 && pend2[0].due == cyc) begin
        exp_q2 = ref_out(th, pend2[0].x);
        exp_v2 = 1;
        void'(pend2.pop_front());
      end
      exp_v3 = 0;
      if (pend3.size() > 0 && pend3[0].due == cyc) begin
        exp_q3 = ref_out(th, pend3[0].x);
        exp_v3 = 1;
        void'(pend3.pop_front());
      end
      if (v) begin
        b.x = x;
        b.due = cyc + 1; pend2.push_back(b);
        b.due = cyc + 2; pend3.push_back(b);
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t       tbl[6];
    bit         pat[6];
    bit [3:0]   seen;
    logic [7:0] q_prev;
    logic [7:0] s2_last;
    logic [11:0] s3_last;
    int         stale, ch0, ch1, ch3;

    tbl[0] = '{4'hD, 2'b10, 4'hE};
    tbl[1] = '{4'h3, 2'b01, 4'h4};
    tbl[2] = '{4'hF, 2'b11, 4'hF};
    tbl[3] = '{4'h6, 2'b10, 4'h7};
    tbl[4] = '{4'h9, 2'b01, 4'hB};
    tbl[5] = '{4'h0, 2'b11, 4'h0};

    repeat (2) @(negedge clk);
    check("reset_q_s2", q2, 0);
    check("reset_valid_s2", vo2, 0);
    check("reset_q_s3", q3, 0);
    check("reset_valid_s3", vo3, 0);

    // Unmasked directed vectors on the 2-share instance.
    foreach (tbl[k]) begin
      step(0, 1, tbl[k].x, 2'b00, 0);
      check("tbl_no_early_valid", vo2, 0);
      step(0, 0, 4'h0, tbl[k].th, 0);
      check("tbl_valid", vo2, 1);
      check("tbl_share0", q2[3:0], tbl[k].q);
      check("tbl_share1", q2[7:4], 0);
    end
    repeat (3) step(0, 0, 4'h0, 2'b00, 0);

    // Bubble pattern 1,1,0,1.
    pat = '{1, 1, 0, 1, 0, 0};
    seen = '0;
    q_prev = '0;
    for (int k = 0; k < 6; k++) begin
      step(0, pat[k], 4'($urandom), 2'($urandom_range(1, 3)), 1);
      if (k >= 1 && k <= 4) seen[k-1] = vo2;
      if (k == 2) q_prev = q2;
      if (k == 3) check("bubble_hold", q2, q_prev);
    end
    check("bubble_pattern", seen, 4'b1011);

    // Identity theta on the 3-share instance.
    step(0, 1, 4'h6, 2'b11, 1);
    step(0, 0, 4'h0, 2'b11, 1);
    check("id_s3_not_yet", vo3, 0);
    step(0, 0, 4'h0, 2'b11, 1);
    check("id_s3_valid", vo3, 1);
    check("id_s3_q", fold3(q3), 4'h9);

    // Reset with beats in flight, then normal latency after release.
    step(0, 1, 4'hA, 2'b10, 1);
    step(0, 1, 4'h5, 2'b01, 1);
    step(1, 0, 4'h0, 2'b11, 1);
    stale = 0;
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 4'h0, 2'($urandom), 1);
      stale += int'(vo2) + int'(vo3);
    end
    check("no_stale_beat", stale, 0);
    step(0, 1, 4'hD, 2'b00, 1);
    step(0, 0, 4'h0, 2'b10, 1);
    check("post_rst_valid_s2", vo2, 1);
    check("post_rst_q_s2", fold2(q2), 4'hE);
    step(0, 0, 4'h0, 2'b10, 1);
    check("post_rst_valid_s3", vo3, 1);
    check("post_rst_q_s3", fold3(q3), 4'hE);

    // Reset coinciding with a beat drops that beat.
    step(1, 1, 4'h7, 2'b11, 1);
    stale = 0;
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 4'h0, 2'b11, 1);
      stale += int'(vo2) + int'(vo3);
    end
    check("rst_with_valid_dropped", stale, 0);

    // Z independence: fixed X and theta shares, only Z varies.
    ch0 = 0; ch1 = 0; ch3 = 0;
    s2_last = '0; s3_last = '0;
    for (int k = 0; k < 40; k++) begin
      step(0, 1, 4'hD, 2'b10, 2);
      if (k >= 3) begin
        if (q2[3:0] != s2_last[3:0]) ch0++;
        if (q2[7:4] != s2_last[7:4]) ch1++;
        if (q3 != s3_last) ch3++;
      end
      s2_last = q2;
      s3_last = q3;
    end
    check("zind_unmasked_s2", fold2(q2), 4'hE);
    check("zind_unmasked_s3", fold3(q3), 4'hE);
    check("zind_share0_varies", ch0 > 0, 1);
    check("zind_share1_varies", ch1 > 0, 1);
    check("zind_s3_varies", ch3 > 0, 1);

    // Randomized masked traffic.
    for (int k = 0; k < 10000; k++) begin
      step(0, $urandom_range(0, 3) != 0, 4'($urandom), 2'($urandom), 1);
    end
    repeat (4) step(0, 0, 4'h0, 2'($urandom), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dom_shared_inv_out_gf4.md
# dom_shared_inv_out_gf4

Masked GF(2^4) inversion output stage for the DOM AES S-box datapath. It sits directly downstream of the shared GF(2^2) square-scale-multiply stage and consumes that stage's shared GF(2^2) inverse θ. It multiplies θ with the delay-aligned high and low halves of the shared GF(2^4) operand X, using two DOM-indep GF(2^2) multipliers, and emits the shared GF(2^4) inverse in normal basis. Valid-tagged pipeline with no backpressure.

## Interface
- SHARES, 2: number of Boolean shares (≥2).
- UPSTREAM_LATENCY, 1: cycles from X entering the upstream stage to θ being valid at this block (≥1).
- ClkxCI  in  1  clock, rising edge.
- RstxRI  in  1  reset, asynchronous, active-high.
- ValidxSI  in  1  X beat valid, same cycle as _XxDI.
- _XxDI  in  4*SHARES  shared X; share i at [4i+3:4i]: bits [4i+3:4i+2] = Xh, [4i+1:4i] = Xl.
- _InvxDI  in  2*SHARES  shared θ = (Xh·Xl ⊕ sqsc(Xh⊕Xl))^-1; share i at [2i+1:2i]; valid UPSTREAM_LATENCY cycles after the matching ValidxSI.
- _ZxDI  in  SHARES*(SHARES-1)*2  fresh randomness: low half for the high-output multiplier, high half for the low-output multiplier; SHARES*(SHARES-1)/2 2-bit words each; word for pair (i<j) at index k(i,j) in row-major upper-triangle order.
- _QxDO  out  4*SHARES  shared X^-1, same packing as _XxDI.
- ValidxSO  out  1  _QxDO valid.

## Operation
- Align stage: UPSTREAM_LATENCY-deep shift register carrying {valid, X shares}. A stage loads only when its incoming valid is 1; its valid bit always loads. Gaps in ValidxSI therefore propagate as bubbles, and data registers hold their last value during bubbles.
- Output-high share i = θ·Xl (DOM-indep). Output-low share i = θ·Xh (DOM-indep). This is the Canright normal-basis inverse.
- GF(2^2) normal-basis multiply on 2-bit a, b:
  - e = (a1⊕a0)&(b1⊕b0)
  - q1 = (a1&b1)⊕e
  - q0 = (a0&b0)⊕e
  - Multiplicative identity is 2'b11.
- DOM-indep, per multiplier:
  - Inner term θ_i·X_i goes to register R[i][i].
  - Cross term (i≠j) θ_i·X_j ⊕ Z_k(i,j) goes to register R[i][j].
  - Q_i = XOR over j of R[i][j], combinational from registers only.
  - All R registers load when the delayed valid is 1.
- Each fresh Z word is used in exactly two cross terms (ij and ji). Z must be fresh on every cycle in which the delayed valid is 1, and is ignored otherwise.
- Glitch rule: no combinational path mixes shares before a register.
- Reset: all align registers, R registers and valid bits clear to 0 immediately. _QxDO = 0 and ValidxSO = 0 while RstxRI is high and until the first beat completes. A beat in flight at reset is discarded.

## Timing
- Latency: ValidxSI at cycle t gives ValidxSO at t+UPSTREAM_LATENCY+1. θ for that beat is sampled at t+UPSTREAM_LATENCY.
- Throughput: one beat per cycle. Back-to-back beats are independent.
- ValidxSO is a registered bit. _QxDO is an XOR of registers (one LUT level) and is stable for the whole cycle.
- Reset deasserted mid-stream: the first ValidxSO appears UPSTREAM_LATENCY+1 cycles after the first post-reset ValidxSI.
- Simultaneous reset and ValidxSI: reset wins and the beat is dropped.

## Structure
- Shared package entries:
  - function gf4_nb_mul(a, b).
  - function n_rnd_pairs(SHARES) = SHARES*(SHARES-1)/2.
  - function pair_idx(i, j).
  - localparams for bit positions of Xh and Xl.
- Sub-module dom_indep_mul_gf2: parameter SHARES; ports ClkxCI, RstxRI, EnxSI, _AxDI, _BxDI, _ZxDI, _QxDO.
  - Instantiated twice.
  - Uses the codebase gf2_mul #(.N(2)) for partial products.
- Top level holds the align shift register, the valid pipeline and the output repacking.

## Test plan
- Unmasked case: SHARES=2, UPSTREAM_LATENCY=1, share1=0, Z=0. X0=4'hD, θ0=2'b10 one cycle later. Required: _QxDO share0=4'hE, share1=0, ValidxSO at t+2.
- Masked case: random X, θ and Z over 10^4 beats. XOR of output shares must equal the reference product: {θ·Xl, θ·Xh} for all beats. Both shares must change across beats with equal unmasked values.
- Back-to-back beats with a bubble pattern 1,1,0,1. ValidxSO must follow the pattern 1,1,0,1 exactly 2 cycles later, with the correct data on each beat. _QxDO holds its value during the bubble.
- Reset mid-stream: assert RstxRI while 2 beats are in flight. _QxDO=0 and ValidxSO=0 immediately, no stale beat emerges, and the next beat after release has normal latency.
- SHARES=3, UPSTREAM_LATENCY=2: identity check with θ=2'b11. The XOR of _QxDO shares equals {Xl, Xh} at t+3.
- Z independence: hold X and θ fixed and vary Z. The unmasked output is constant and the individual shares vary.
